// File: rtl/noc_mux_buffered.sv
// noc_mux_buffered
// Packet-atomic N-to-1 flit multiplexer with a registered output FIFO.
// One input channel wins arbitration, either round-robin or fixed priority
// (lowest index). The winner then owns the output until its last flit has been
// accepted (wormhole lock). Accepted flits go into a small FIFO. The output side
// is driven only from FIFO registers, so out_* never depends combinationally on
// out_ready or on any input.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_flit      packed per-channel flit data
//   in_last      per-channel last-flit marker
//   in_valid     per-channel flit valid
//   in_ready     per-channel accept (at most one bit high)
//   out_flit     FIFO head flit (0 when empty)
//   out_last     FIFO head last marker (0 when empty)
//   out_valid    FIFO not empty
//   out_ready    downstream accepts the head flit
//   cur_channel  current owner while locked, otherwise the most recent owner
//   locked       a multi-flit packet is in progress
module noc_mux_buffered #(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int ARB_MODE     = 0,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]                 in_last,
  input  logic [CHANNELS-1:0]                 in_valid,
  output logic [CHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cur_channel,
  output logic                                locked
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(BUFFER_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Returns {found, index} of the first requester at or after 'start',
  // wrapping around. Scanning downward lets the smallest offset win.
  function automatic logic [CW:0] find_first(input logic [CHANNELS-1:0] req,
                                             input int start);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = (start + i) % CHANNELS;
      if (req[idx]) begin
        res = {1'b1, CW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t          state_r;
  logic [CW-1:0]   owner_r;
  logic [CW-1:0]   last_owner_r;
  logic [CW-1:0]   cur_channel_r;
  logic            locked_r;

  logic [FLIT_WIDTH:0] mem_r [BUFFER_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  logic [CW-1:0]   grant_s;
  logic            req_s;
  logic [CW:0]     search_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            push_last_s;
  logic [FLIT_WIDTH-1:0] push_flit_s;
  logic            head_valid_s;

  assign full_s       = (count_r == CNT_FULL);
  assign head_valid_s = (count_r != '0);
  assign push_s       = req_s & ~full_s;
  assign pop_s        = head_valid_s & out_ready;
  assign push_flit_s  = in_flit[grant_s];
  assign push_last_s  = in_last[grant_s];

  // Grant selection: the owner while locked, otherwise arbitrate among requesters.
  always_comb begin
    grant_s  = owner_r;
    req_s    = 1'b0;
    search_s = '0;
    if (state_r == ST_LOCKED) begin
      grant_s = owner_r;
      req_s   = in_valid[owner_r];
    end else begin
      if (ARB_MODE == 1) begin
        search_s = find_first(in_valid, 0);
      end else begin
        search_s = find_first(in_valid, int'(last_owner_r) + 1);
      end
      grant_s = search_s[CW-1:0];
      req_s   = search_s[CW];
    end
  end

  // One-hot ready to the granted channel, only when it requests and there is room.
  always_comb begin
    in_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c] = push_s & (grant_s == CW'(c));
    end
  end

  // Packet lock FSM and owner/status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      owner_r       <= '0;
      last_owner_r  <= LAST_CH;
      cur_channel_r <= LAST_CH;
      locked_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s) begin
            cur_channel_r <= grant_s;
            if (push_last_s) begin
              last_owner_r <= grant_s;
            end else begin
              state_r  <= ST_LOCKED;
              owner_r  <= grant_s;
              locked_r <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (push_s && push_last_s) begin
            state_r       <= ST_IDLE;
            last_owner_r  <= owner_r;
            cur_channel_r <= owner_r;
            locked_r      <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents are masked at the output while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {push_last_s, push_flit_s};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign out_valid   = head_valid_s;
  assign out_flit    = head_valid_s ? mem_r[rd_ptr_r][FLIT_WIDTH-1:0] : '0;
  assign out_last    = head_valid_s ? mem_r[rd_ptr_r][FLIT_WIDTH] : 1'b0;
  assign cur_channel = cur_channel_r;
  assign locked      = locked_r;

endmodule

// File: tb/tb_noc_mux_buffered.sv
module tb_noc_mux_buffered;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: round-robin, 2 channels
  logic [1:0][7:0] a_flit;
  logic [1:0]      a_last, a_valid, a_ready;
  logic [7:0]      a_oflit;
  logic            a_olast, a_ovalid, a_oready, a_locked;
  logic [0:0]      a_cur;

  // DUT B: fixed priority, 4 channels
  logic [3:0][7:0] b_flit;
  logic [3:0]      b_last, b_valid, b_ready;
  logic [7:0]      b_oflit;
  logic            b_olast, b_ovalid, b_oready, b_locked;
  logic [1:0]      b_cur;

  // DUT C: round-robin, 4 channels
  logic [3:0][7:0] c_flit;
  logic [3:0]      c_last, c_valid, c_ready;
  logic [7:0]      c_oflit;
  logic            c_olast, c_ovalid, c_oready, c_locked;
  logic [1:0]      c_cur;

  noc_mux_buffered #(.FLIT_WIDTH(8), .CHANNELS(2), .ARB_MODE(0), .BUFFER_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .in_flit(a_flit), .in_last(a_last), .in_valid(a_valid),
    .in_ready(a_ready), .out_flit(a_oflit), .out_last(a_olast), .out_valid(a_ovalid),
    .out_ready(a_oready), .cur_channel(a_cur), .locked(a_locked));

  noc_mux_buffered #(.FLIT_WIDTH(8), .CHANNELS(4), .ARB_MODE(1), .BUFFER_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_flit(b_flit), .in_last(b_last), .in_valid(b_valid),
    .in_ready(b_ready), .out_flit(b_oflit), .out_last(b_olast), .out_valid(b_ovalid),
    .out_ready(b_oready), .cur_channel(b_cur), .locked(b_locked));

  noc_mux_buffered #(.FLIT_WIDTH(8), .CHANNELS(4), .ARB_MODE(0), .BUFFER_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .in_flit(c_flit), .in_last(c_last), .in_valid(c_valid),
    .in_ready(c_ready), .out_flit(c_oflit), .out_last(c_olast), .out_valid(c_ovalid),
    .out_ready(c_oready), .cur_channel(c_cur), .locked(c_locked));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arm a reset: held across the next rising edge, released by the next drive.
  task automatic arm_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
  endtask

  typedef struct {
    bit         rst_pre;
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] f0;
    logic [7:0] f1;
    logic       ordy;
    logic [1:0] erdy;
    logic       eov;
    logic [7:0] eflit;
    logic       elast;
    logic       ecur;
    logic       elock;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rp, logic [1:0] v, logic [1:0] l, logic [7:0] f0,
                              logic [7:0] f1, logic ordy, logic [1:0] erdy, logic eov,
                              logic [7:0] eflit, logic elast, logic ecur, logic elock);
    vec_t r;
    r.rst_pre = rp; r.v = v; r.l = l; r.f0 = f0; r.f1 = f1; r.ordy = ordy;
    r.erdy = erdy; r.eov = eov; r.eflit = eflit; r.elast = elast; r.ecur = ecur;
    r.elock = elock;
    return r;
  endfunction

  initial begin
    a_flit = '0; a_last = '0; a_valid = '0; a_oready = 1'b1;
    b_flit = '0; b_last = '0; b_valid = '0; b_oready = 1'b1;
    c_flit = '0; c_last = '0; c_valid = '0; c_oready = 1'b1;

    // Round-robin alternation of single-flit packets
    tbl.push_back(mk(1, 2'b11, 2'b11, 8'hA0, 8'hB0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 8'hA1, 8'hB0, 1'b1, 2'b10, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 8'hA1, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 8'hA2, 8'hB1, 1'b1, 2'b10, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 8'hA2, 8'hB2, 1'b1, 2'b01, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0));
    // Wormhole lock: ch1 4-flit packet while ch0 waits
    tbl.push_back(mk(1, 2'b10, 2'b01, 8'hC0, 8'h10, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'hC0, 8'h11, 1'b1, 2'b10, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'hC0, 8'h12, 1'b1, 2'b10, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(0, 2'b11, 2'b11, 8'hC0, 8'h13, 1'b1, 2'b10, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'hC0, 8'h00, 1'b1, 2'b01, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    // Backpressure: FIFO fills at 2, full blocks even with a pop, refills after pop
    tbl.push_back(mk(1, 2'b01, 2'b01, 8'h20, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h21, 8'h00, 1'b0, 2'b01, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h22, 8'h00, 1'b0, 2'b00, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h22, 8'h00, 1'b1, 2'b00, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h22, 8'h00, 1'b0, 2'b01, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h23, 8'h00, 1'b1, 2'b00, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    // Reset in the middle of a 4-flit packet from ch0
    tbl.push_back(mk(1, 2'b01, 2'b00, 8'h30, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h31, 8'h00, 1'b0, 2'b01, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1, 2'b11, 2'b11, 8'h40, 8'h50, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_pre) arm_reset();
      @(negedge clk);
      rst = 1'b0;
      a_valid = tbl[i].v; a_last = tbl[i].l;
      a_flit[0] = tbl[i].f0; a_flit[1] = tbl[i].f1;
      a_oready = tbl[i].ordy;
      #2;
      check($sformatf("row%0d in_ready", i), 32'(a_ready), 32'(tbl[i].erdy));
      check($sformatf("row%0d out_valid", i), 32'(a_ovalid), 32'(tbl[i].eov));
      check($sformatf("row%0d out_flit", i), 32'(a_oflit), 32'(tbl[i].eflit));
      check($sformatf("row%0d out_last", i), 32'(a_olast), 32'(tbl[i].elast));
      check($sformatf("row%0d cur_channel", i), 32'(a_cur), 32'(tbl[i].ecur));
      check($sformatf("row%0d locked", i), 32'(a_locked), 32'(tbl[i].elock));
    end

    // Fixed priority: ch1 beats ch3 until ch1 drops
    arm_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = 1'b0;
      b_last = 4'b1111;
      b_flit[1] = 8'h60 + 8'(i);
      b_flit[3] = 8'h70;
      b_valid = (i < 4) ? 4'b1010 : ((i == 4) ? 4'b1000 : 4'b0000);
      #2;
      if (i < 4) check($sformatf("fp%0d in_ready", i), 32'(b_ready), 32'h2);
      else if (i == 4) check("fp4 in_ready", 32'(b_ready), 32'h8);
      else check("fp5 in_ready", 32'(b_ready), 32'h0);
      if (i == 0) begin
        check("fp0 out_valid", 32'(b_ovalid), 32'h0);
        check("fp0 cur_channel", 32'(b_cur), 32'h3);
      end else if (i < 5) begin
        check($sformatf("fp%0d out_flit", i), 32'(b_oflit), 32'h60 + 32'(i - 1));
        check($sformatf("fp%0d cur_channel", i), 32'(b_cur), 32'h1);
      end else begin
        check("fp5 out_flit", 32'(b_oflit), 32'h70);
        check("fp5 cur_channel", 32'(b_cur), 32'h3);
      end
    end

    // Round-robin wrap over 4 channels
    arm_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0;
      b_valid = '0;
      c_last = 4'b1111;
      c_valid = 4'b1111;
      for (int k = 0; k < 4; k++) c_flit[k] = 8'hD0 + 8'(k);
      #2;
      check($sformatf("rr%0d in_ready", i), 32'(c_ready), 32'(4'b0001 << (i % 4)));
      if (i == 0) begin
        check("rr0 cur_channel", 32'(c_cur), 32'h3);
        check("rr0 out_valid", 32'(c_ovalid), 32'h0);
      end else begin
        check($sformatf("rr%0d cur_channel", i), 32'(c_cur), 32'((i - 1) % 4));
        check($sformatf("rr%0d out_flit", i), 32'(c_oflit), 32'h0D0 + 32'((i - 1) % 4));
      end
    end

    @(negedge clk);
    c_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
